// File: rtl/regfile_if.sv
// Register-file access bundle: decode read ports, write-back port, debug read and status.
// Strict valid/ready semantics do not apply; ready is a level that, once 1, qualifies every port.
interface regfile_if #(
  parameter int REG_AW = 5,
  parameter int DW     = 32
);
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [DW-1:0]     wdata;
  logic              re1;
  logic [REG_AW-1:0] raddr1;
  logic [DW-1:0]     rdata1;
  logic              re2;
  logic [REG_AW-1:0] raddr2;
  logic [DW-1:0]     rdata2;
  logic [REG_AW-1:0] dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic              ready;
  logic              dbg_state;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data, ready, dbg_state
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data, ready, dbg_state
  );
endinterface

// File: rtl/regfile.sv
// 32x32 register file: two bypassed combinational read ports, one write port,
// post-reset clear sequencer and a registered debug read port.
module regfile #(
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5,
  parameter int DW      = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [REG_AW:0] CNT_LAST = (REG_AW+1)'(REG_NUM - 1);

  logic [0:0]        state_q, state_d;
  logic [REG_AW:0]   clr_cnt_q, clr_cnt_d;
  logic [DW-1:0]     dbg_data_q, dbg_data_d;
  logic [DW-1:0]     mem_q [REG_NUM];

  logic              mem_we;
  logic [REG_AW-1:0] mem_waddr;
  logic [DW-1:0]     mem_wdata;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q[REG_AW-1:0];
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CNT_LAST) state_d = ST_RUN;
    end else if (bus.we && (bus.waddr != '0)) begin
      mem_we = 1'b1;
    end
  end

  // Debug read sees the array before this edge's write lands (no bypass).
  always_comb begin
    dbg_data_d = '0;
    if (state_q == ST_RUN && bus.dbg_addr != '0) dbg_data_d = mem_q[bus.dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  function automatic logic [DW-1:0] rd_port(
    input logic              rst_n,
    input logic              run,
    input logic              re,
    input logic [REG_AW-1:0] ra,
    input logic              we,
    input logic [REG_AW-1:0] wa,
    input logic [DW-1:0]     wd,
    input logic [DW-1:0]     arr_val
  );
    if (!rst_n || !run || !re || ra == '0) return '0;
    if (we && wa == ra) return wd;
    return arr_val;
  endfunction

  always_comb begin
    bus.rdata1 = rd_port(rst, state_q == ST_RUN, bus.re1, bus.raddr1,
                         bus.we, bus.waddr, bus.wdata, mem_q[bus.raddr1]);
    bus.rdata2 = rd_port(rst, state_q == ST_RUN, bus.re2, bus.raddr2,
                         bus.we, bus.waddr, bus.wdata, mem_q[bus.raddr2]);
  end

  assign bus.dbg_data  = dbg_data_q;
  assign bus.ready     = (state_q == ST_RUN);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: clear sequencing, bypass, r0 protection, resets, dual ports.
module tb_regfile;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  regfile_if #(.REG_AW(5), .DW(32)) rf ();

  regfile #(.REG_NUM(32), .REG_AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf.we = 1'b1; rf.waddr = a; rf.wdata = d;
    step();
    rf.we = 1'b0;
  endtask

  // Holds rst low for 'low' edges, releases, and counts cycles until ready.
  // With poke set, a write to r3 is presented throughout the clear.
  task automatic do_reset(input int low, input bit poke, output int n);
    rst = 1'b0;
    repeat (low) step();
    rst = 1'b1;
    if (poke) begin
      rf.we = 1'b1; rf.waddr = 5'd3; rf.wdata = 32'hFFFF_FFFF;
      rf.re1 = 1'b1; rf.raddr1 = 5'd3;
    end
    n = 0;
    while (!rf.ready && n < 100) begin
      if (poke && n == 10) chk("clear_rd_no_bypass", rf.rdata1, 32'h0);
      step();
      n++;
    end
    rf.we = 1'b0; rf.re1 = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    rf.we = 1'b0; rf.waddr = '0; rf.wdata = '0;
    rf.re1 = 1'b0; rf.raddr1 = '0; rf.re2 = 1'b0; rf.raddr2 = '0;
    rf.dbg_addr = '0;
    step(); step();
    chk("rst_ready", {31'b0, rf.ready}, 32'h0);
    chk("rst_dbg", rf.dbg_data, 32'h0);

    // Bring-up, then preload garbage
    do_reset(1, 1'b0, n);
    chk("init_clear_len", n, 32);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA000_0000 | i);

    // Reset 2 cycles with garbage present; reads must be 0 while rst low
    rst = 1'b0; rf.re1 = 1'b1; rf.raddr1 = 5'd5; #1;
    chk("rst_low_rd1", rf.rdata1, 32'h0);
    rf.re1 = 1'b0;
    do_reset(2, 1'b1, n);
    chk("clear_len", n, 32);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 32; i++) begin
      rf.dbg_addr = 5'(i);
      step();
      chk($sformatf("sweep_r%0d", i), rf.dbg_data, exp_q.pop_front());
    end

    // Basic write / read
    wr(5'd5, 32'h1234_5678);
    rf.re1 = 1'b1; rf.raddr1 = 5'd5; #1;
    chk("basic_rd1", rf.rdata1, 32'h1234_5678);
    rf.re1 = 1'b0; #1;
    chk("basic_re0", rf.rdata1, 32'h0);

    // Bypass on both ports, debug shows pre-write then post-write
    wr(5'd7, 32'h0000_0001);
    rf.we = 1'b1; rf.waddr = 5'd7; rf.wdata = 32'hDEAD_BEEF;
    rf.re1 = 1'b1; rf.raddr1 = 5'd7; rf.re2 = 1'b1; rf.raddr2 = 5'd7;
    rf.dbg_addr = 5'd7; #1;
    chk("byp_rd1", rf.rdata1, 32'hDEAD_BEEF);
    chk("byp_rd2", rf.rdata2, 32'hDEAD_BEEF);
    step();
    rf.we = 1'b0;
    chk("byp_dbg_old", rf.dbg_data, 32'h0000_0001);
    step();
    chk("byp_dbg_new", rf.dbg_data, 32'hDEAD_BEEF);
    rf.re2 = 1'b0;

    // r0 protection
    rf.we = 1'b1; rf.waddr = 5'd0; rf.wdata = 32'hA5A5_A5A5;
    rf.re1 = 1'b1; rf.raddr1 = 5'd0; rf.dbg_addr = 5'd0; #1;
    chk("r0_same_cycle", rf.rdata1, 32'h0);
    step();
    rf.we = 1'b0; #1;
    chk("r0_after", rf.rdata1, 32'h0);
    step();
    chk("r0_dbg", rf.dbg_data, 32'h0);
    rf.re1 = 1'b0;

    // Dual-port independence with concurrent write
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    rf.re1 = 1'b1; rf.raddr1 = 5'd2; rf.re2 = 1'b1; rf.raddr2 = 5'd1;
    rf.we = 1'b1; rf.waddr = 5'd9; rf.wdata = 32'h99; #1;
    chk("dual_rd1", rf.rdata1, 32'h22);
    chk("dual_rd2", rf.rdata2, 32'h11);
    step();
    rf.we = 1'b0; rf.raddr1 = 5'd9; #1;
    chk("dual_r9", rf.rdata1, 32'h99);
    rf.re1 = 1'b0; rf.re2 = 1'b0;

    // Reset mid-RUN
    wr(5'd31, 32'hCAFE_BABE);
    rf.re1 = 1'b1; rf.raddr1 = 5'd31; #1;
    chk("r31_written", rf.rdata1, 32'hCAFE_BABE);
    rst = 1'b0; #1;
    chk("run_rst_ready_hold", {31'b0, rf.ready}, 32'h1);
    chk("run_rst_rd_zero", rf.rdata1, 32'h0);
    step();
    chk("run_rst_ready_drop", {31'b0, rf.ready}, 32'h0);
    rst = 1'b1;
    n = 0;
    while (!rf.ready && n < 100) begin step(); n++; end
    chk("run_rst_clear_len", n, 32);
    rf.re1 = 1'b1; rf.raddr1 = 5'd31; #1;
    chk("r31_cleared", rf.rdata1, 32'h0);
    rf.re1 = 1'b0;

    // Reset during cycle 10 of CLEAR restarts the full clear
    rst = 1'b0; step(); rst = 1'b1;
    repeat (10) step();
    chk("mid_clear_not_ready", {31'b0, rf.ready}, 32'h0);
    do_reset(1, 1'b0, n);
    chk("mid_clear_restart_len", n, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile.md
# regfile

General-purpose register file that answers the decode stage's operand read requests and absorbs write-back results. It holds 32 x 32-bit registers, provides two combinational read ports with same-cycle write-to-read bypass, and one write port driven from write-back. A post-reset clear sequencer zeroes the array before the pipeline is released. A registered debug read port serves the test harness.

## Interface
Parameters:
- REG_NUM, 32, number of registers (power of two)
- REG_AW, 5, register address width (log2 REG_NUM)
- DW, 32, data width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- we  input  1  write enable from write-back
- waddr  input  REG_AW  write register address
- wdata  input  DW  write data
- re1  input  1  read port 1 enable
- raddr1  input  REG_AW  read port 1 address
- rdata1  output  DW  read port 1 data (combinational)
- re2  input  1  read port 2 enable
- raddr2  input  REG_AW  read port 2 address
- rdata2  output  DW  read port 2 data (combinational)
- dbg_addr  input  REG_AW  debug read address
- dbg_data  output  DW  debug read data (registered)
- ready  output  1  1 = clear done, array usable

## Operation
- States: CLEAR and RUN. Reset (rst=0) forces CLEAR with clr_cnt=0 on the next edge. Reset mid-CLEAR or mid-RUN restarts the clear from entry 0.
- CLEAR: each cycle writes 0 to entry clr_cnt, then clr_cnt increments. The cycle that clears entry REG_NUM-1 transitions to RUN. The count is REG_AW+1 bits wide, so there is no wrap.
- CLEAR: we is ignored and never reaches the array. rdata1, rdata2 and dbg_data read 0. ready=0.
- RUN: ready=1.
- RUN write: if we=1 and waddr!=0, then wdata is stored at waddr on the edge. Writes to r0 are discarded; r0 always reads 0.
- RUN read port n, evaluated in order of priority:
  - rst=0 -> 0
  - ren=0 -> 0
  - raddrn=0 -> 0
  - we=1 and waddr==raddrn -> wdata (bypass)
  - otherwise array[raddrn]
- Both read ports are independent. Both may hit the same address, and both may bypass in the same cycle.
- Debug port: dbg_data <= array[dbg_addr] on each edge, with no bypass, so it shows the pre-write value when a write to that address lands in the same cycle. dbg_addr=0 gives 0.
- No arithmetic beyond the clr_cnt increment. Data is stored and returned unmodified at full DW width.

## Timing
- Reset values:
  - state=CLEAR, clr_cnt=0
  - ready=0, dbg_data=0
  - rdata1=rdata2=0 while rst=0
- Clear latency: rst rises at edge E0. The first clear write happens at E0+1. ready goes to 1 after edge E0+REG_NUM (32 cycles).
- Write latency: a value written at edge E is visible through the array from E onward. In the cycle before E it is already visible through the bypass.
- Read latency: zero cycles, so rdata follows raddr, ren, we, waddr and wdata combinationally.
- Debug latency: one cycle.
- Upstream holds issue until ready=1. Behaviour for writes presented before then is defined above: they are dropped.

## Test plan
- Reset/clear:
  - Stimulus: preload garbage by running with rst high, then pull rst=0 for 2 cycles and release.
  - Response: ready=0 for exactly 32 cycles, then 1.
  - Response: dbg_data sweep over r0..r31 all read 0x00000000.
  - Response: we=1, waddr=3, wdata=0xFFFFFFFF during CLEAR leaves r3=0.
- Basic write/read:
  - Stimulus: write r5=0x12345678, next cycle re1=1, raddr1=5.
  - Response: rdata1=0x12345678.
  - Response: re1=0 with the same address gives rdata1=0.
- Bypass:
  - Stimulus: same cycle we=1, waddr=7, wdata=0xDEADBEEF, re1=re2=1, raddr1=raddr2=7, with r7 previously 0x1.
  - Response: both rdata1 and rdata2=0xDEADBEEF.
  - Response: dbg_addr=7 in that cycle gives dbg_data=0x1 on the next edge, and 0xDEADBEEF one cycle later.
- r0 protection:
  - Stimulus: we=1, waddr=0, wdata=0xA5A5A5A5 with raddr1=0, re1=1.
  - Response: rdata1=0 in that cycle and afterwards.
  - Response: dbg_data for r0 is 0.
- Reset mid-operation:
  - Stimulus: write r31=0xCAFEBABE, assert rst=0 for 1 cycle in RUN.
  - Response: ready drops the cycle after.
  - Response: 32-cycle clear, after which r31 reads 0.
  - Stimulus: assert rst during cycle 10 of CLEAR.
  - Response: a full 32-cycle clear restarts.
- Dual-port independence:
  - Stimulus: r1=0x11, r2=0x22, raddr1=2, raddr2=1, concurrent write r9=0x99.
  - Response: rdata1=0x22, rdata2=0x11, unaffected by the write.
